// File: rtl/wpu_weight_decoder.sv
// Walks weight and compensation memories column by column and streams
// reconstructed 8-bit weights to the array loader over valid/ready.
module wpu_weight_decoder #(
  parameter int SIZE            = 8,
  parameter int MEM_SIZE        = SIZE * SIZE,
  parameter int ADDR_WIDTH      = $clog2(MEM_SIZE),
  parameter int CROW_WIDTH      = $clog2(SIZE),
  parameter int CMEM_SIZE       = SIZE * 3,
  parameter int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       Weight_Mem_Rd_En,
  output logic [ADDR_WIDTH-1:0]      Weight_Mem_Rd_Addr,
  input  logic [4:0]                 Reduced_Weight_in,
  output logic                       Comp_Mem_Rd_En,
  output logic [CMEM_ADDR_WIDTH-1:0] Comp_Mem_Rd_Addr,
  input  logic [CROW_WIDTH+3:0]      Comp_Entry_in,
  output logic [7:0]                 Weight_out,
  output logic [ADDR_WIDTH-1:0]      Weight_Addr_out,
  output logic                       Weight_out_valid,
  input  logic                       Weight_out_ready
);

  localparam int NSLOT = 3;
  localparam logic [CROW_WIDTH:0]   ROWS     = (CROW_WIDTH+1)'(SIZE);
  localparam logic [CROW_WIDTH-1:0] LAST_IDX = CROW_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] SIZE_A   = ADDR_WIDTH'(SIZE);

  typedef enum logic [1:0] {IDLE, LOAD_COMP, STREAM, DONE_S} state_t;

  state_t                    state_reg;
  logic [CROW_WIDTH-1:0]     col_reg;
  logic [1:0]                ld_cnt_reg;
  logic [CROW_WIDTH:0]       rd_cnt_reg;
  logic                      pend_reg;
  logic [CROW_WIDTH-1:0]     pend_row_reg;
  logic [ADDR_WIDTH-1:0]     pend_addr_reg;
  logic [CROW_WIDTH-1:0]     out_row_reg;
  logic                      slot_valid_reg [NSLOT];
  logic [CROW_WIDTH-1:0]     slot_row_reg   [NSLOT];
  logic [2:0]                slot_cw_reg    [NSLOT];

  logic [NSLOT-1:0]          hit_vec;
  logic                      hit;
  logic [2:0]                hit_cw;
  logic [7:0]                recon;
  logic                      accept;
  logic                      last_accept;
  logic [CROW_WIDTH-1:0]     rd_row;

  assign rd_row      = rd_cnt_reg[CROW_WIDTH-1:0];
  assign accept      = Weight_out_valid && Weight_out_ready;
  assign last_accept = accept && (out_row_reg == LAST_IDX);

  // A read may only be issued into a free (or draining) 1-deep output slot.
  assign Weight_Mem_Rd_En   = (state_reg == STREAM) && !pend_reg && (rd_cnt_reg < ROWS)
                              && (!Weight_out_valid || Weight_out_ready);
  assign Weight_Mem_Rd_Addr = ADDR_WIDTH'(col_reg) * SIZE_A + ADDR_WIDTH'(rd_row);

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_match
    assign hit_vec[gi] = slot_valid_reg[gi] && (slot_row_reg[gi] == pend_row_reg);
  end

  // Scan from the top slot down so the lowest matching slot wins.
  always_comb begin
    hit    = 1'b0;
    hit_cw = 3'b000;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit    = 1'b1;
        hit_cw = slot_cw_reg[i];
      end
    end
    if (Reduced_Weight_in[4]) begin
      recon = hit ? {Reduced_Weight_in[3:0], hit_cw, 1'b0}
                  : {Reduced_Weight_in[3:0], 4'b0000};
    end else begin
      recon = {{3{Reduced_Weight_in[3]}}, Reduced_Weight_in[3:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      col_reg          <= '0;
      ld_cnt_reg       <= '0;
      rd_cnt_reg       <= '0;
      pend_reg         <= 1'b0;
      pend_row_reg     <= '0;
      pend_addr_reg    <= '0;
      out_row_reg      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      Comp_Mem_Rd_En   <= 1'b0;
      Comp_Mem_Rd_Addr <= '0;
      Weight_out       <= '0;
      Weight_Addr_out  <= '0;
      Weight_out_valid <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_valid_reg[i] <= 1'b0;
        slot_row_reg[i]   <= '0;
        slot_cw_reg[i]    <= '0;
      end
    end else begin
      done           <= 1'b0;
      Comp_Mem_Rd_En <= 1'b0;
      pend_reg       <= Weight_Mem_Rd_En;

      if (Weight_Mem_Rd_En) begin
        rd_cnt_reg    <= rd_cnt_reg + 1'b1;
        pend_row_reg  <= rd_row;
        pend_addr_reg <= Weight_Mem_Rd_Addr;
      end

      if (pend_reg) begin
        Weight_out       <= recon;
        Weight_Addr_out  <= pend_addr_reg;
        out_row_reg      <= pend_row_reg;
        Weight_out_valid <= 1'b1;
      end else if (accept) begin
        Weight_out_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg        <= LOAD_COMP;
            busy             <= 1'b1;
            col_reg          <= '0;
            ld_cnt_reg       <= '0;
            Comp_Mem_Rd_En   <= 1'b1;
            Comp_Mem_Rd_Addr <= '0;
          end
        end
        LOAD_COMP: begin
          ld_cnt_reg <= ld_cnt_reg + 2'd1;
          // Entry for slot k arrives one cycle after its read, i.e. at ld_cnt k+1.
          for (int i = 0; i < NSLOT; i++) begin
            if (ld_cnt_reg == 2'(i + 1)) begin
              slot_valid_reg[i] <= Comp_Entry_in[CROW_WIDTH+3];
              slot_row_reg[i]   <= Comp_Entry_in[CROW_WIDTH+2:3];
              slot_cw_reg[i]    <= Comp_Entry_in[2:0];
            end
          end
          if (ld_cnt_reg < 2'd2) begin
            Comp_Mem_Rd_En   <= 1'b1;
            Comp_Mem_Rd_Addr <= Comp_Mem_Rd_Addr + CMEM_ADDR_WIDTH'(1);
          end
          if (ld_cnt_reg == 2'd3) begin
            state_reg  <= STREAM;
            rd_cnt_reg <= '0;
          end
        end
        STREAM: begin
          if (last_accept) begin
            rd_cnt_reg <= '0;
            if (col_reg == LAST_IDX) begin
              state_reg        <= DONE_S;
              done             <= 1'b1;
              busy             <= 1'b0;
              col_reg          <= '0;
              Comp_Mem_Rd_Addr <= '0;
            end else begin
              state_reg        <= LOAD_COMP;
              col_reg          <= col_reg + 1'b1;
              ld_cnt_reg       <= '0;
              Comp_Mem_Rd_En   <= 1'b1;
              Comp_Mem_Rd_Addr <= Comp_Mem_Rd_Addr + CMEM_ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wpu_weight_decoder.sv
// Directed bench for wpu_weight_decoder with behavioural 1-cycle-latency memories.
module tb_wpu_weight_decoder;
  localparam int SIZE = 8;
  localparam int AW   = 6;
  localparam int CRW  = 3;
  localparam int CAW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [4:0]       red_w;
  logic             cr_en;
  logic [CAW-1:0]   cr_addr;
  logic [CRW+3:0]   comp_e;
  logic [7:0]       wout;
  logic [AW-1:0]    waddr;
  logic             wvalid;
  logic             ready;

  logic [4:0]       wmem [64];
  logic [CRW+3:0]   cmem [32];

  int               n_checks = 0;
  int               n_errors = 0;
  logic [7:0]       beat_data [128];
  logic [AW-1:0]    beat_addr [128];
  int               beat_cnt = 0;
  int               done_cnt = 0;

  wpu_weight_decoder #(.SIZE(SIZE)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .Weight_Mem_Rd_En   (wr_en),
    .Weight_Mem_Rd_Addr (wr_addr),
    .Reduced_Weight_in  (red_w),
    .Comp_Mem_Rd_En     (cr_en),
    .Comp_Mem_Rd_Addr   (cr_addr),
    .Comp_Entry_in      (comp_e),
    .Weight_out         (wout),
    .Weight_Addr_out    (waddr),
    .Weight_out_valid   (wvalid),
    .Weight_out_ready   (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) red_w <= wmem[wr_addr];
    if (cr_en) comp_e <= cmem[cr_addr];
  end

  // One line per accepted beat; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wvalid && ready) begin
        if (beat_cnt < 128) begin
          beat_data[beat_cnt] = wout;
          beat_addr[beat_cnt] = waddr;
        end
        $display("beat %0d: addr=%0d data=%02h", beat_cnt, waddr, wout);
        beat_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int cyc;
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),    32'd0);
    chk({tag, "_done"},   32'(done),    32'd0);
    chk({tag, "_wren"},   32'(wr_en),   32'd0);
    chk({tag, "_wraddr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_cren"},   32'(cr_en),   32'd0);
    chk({tag, "_craddr"}, 32'(cr_addr), 32'd0);
    chk({tag, "_wout"},   32'(wout),    32'd0);
    chk({tag, "_waddr"},  32'(waddr),   32'd0);
    chk({tag, "_valid"},  32'(wvalid),  32'd0);
  endtask

  initial begin
    int k;
    int first_valid;
    int done_cyc;
    logic [7:0]    hold_w;
    logic [AW-1:0] hold_a;

    for (int i = 0; i < 64; i++) wmem[i] = 5'b00000;
    for (int i = 0; i < 32; i++) cmem[i] = '0;
    // Column 0: duplicate row-0 entries, invalid slot on row 1.
    cmem[0] = {1'b1, 3'd0, 3'b101};
    cmem[1] = {1'b1, 3'd0, 3'b011};
    cmem[2] = {1'b0, 3'd1, 3'b111};
    // Column 1: compensation on rows 3, 5, 7.
    cmem[3] = {1'b1, 3'd3, 3'b001};
    cmem[4] = {1'b1, 3'd5, 3'b010};
    cmem[5] = {1'b1, 3'd7, 3'b111};
    // Column 4: match on row 1 that must be ignored for R[4]=0.
    cmem[12] = {1'b1, 3'd1, 3'b111};
    wmem[0]  = 5'b10110;
    wmem[1]  = 5'b11111;
    wmem[4]  = 5'b00101;
    for (int i = 8; i < 16; i++) wmem[i] = 5'b10001;
    wmem[18] = 5'b01101;
    wmem[19] = 5'b00011;
    wmem[33] = 5'b01010;
    wmem[34] = 5'b11010;

    rst = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 1: full matrix with ready high, extra start while busy and at done.
    start = 1'b1; k = 0; first_valid = 0; done_cyc = 0;
    while (done_cyc == 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
      end
      if (k == 3) begin
        chk("comp_rd_en_slot2", 32'(cr_en), 32'd1);
        chk("comp_rd_addr_slot2", 32'(cr_addr), 32'd2);
      end
      if (k == 4) chk("comp_rd_en_off", 32'(cr_en), 32'd0);
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (wvalid && first_valid == 0) first_valid = k;
      if (done) done_cyc = k;
    end
    chk("first_valid_cycle", 32'(first_valid), 32'd7);
    chk("done_cycle", 32'(done_cyc), 32'd169);
    chk("busy_at_done", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("start_at_done_busy", 32'(busy), 32'd0);
    chk("start_at_done_cren", 32'(cr_en), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("run1_done_cnt", 32'(done_cnt), 32'd1);
    chk("run1_beats", 32'(beat_cnt), 32'd64);
    for (int i = 0; i < 64; i++) chk($sformatf("run1_addr[%0d]", i), 32'(beat_addr[i]), 32'(i));
    chk("w0_comp_row0",     32'(beat_data[0]),  32'h6A);
    chk("w1_invalid_slot",  32'(beat_data[1]),  32'hF0);
    chk("w2_zero",          32'(beat_data[2]),  32'h00);
    chk("w4_pos_sext",      32'(beat_data[4]),  32'h0A);
    chk("w8_nocomp",        32'(beat_data[8]),  32'h10);
    chk("w11_comp_row3",    32'(beat_data[11]), 32'h12);
    chk("w12_nocomp",       32'(beat_data[12]), 32'h10);
    chk("w13_comp_row5",    32'(beat_data[13]), 32'h14);
    chk("w15_comp_row7",    32'(beat_data[15]), 32'h1E);
    chk("w18_neg_sext",     32'(beat_data[18]), 32'hFA);
    chk("w19_pos_sext",     32'(beat_data[19]), 32'h06);
    chk("w33_match_ignored",32'(beat_data[33]), 32'hF4);
    chk("w34_no_match",     32'(beat_data[34]), 32'hA0);
    chk("w63_zero",         32'(beat_data[63]), 32'h00);

    // Run 2: hold ready low for 5 cycles while address 10 is presented.
    beat_cnt = 0; done_cnt = 0;
    pulse_start();
    k = 0;
    while (!(wvalid && waddr == 6'd10) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("stall_target_seen", 32'(waddr), 32'd10);
    ready = 1'b0;
    hold_w = wout; hold_a = waddr;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_w[%0d]", i),     32'(wout),   32'(hold_w));
      chk($sformatf("stall_a[%0d]", i),     32'(waddr),  32'(hold_a));
      chk($sformatf("stall_v[%0d]", i),     32'(wvalid), 32'd1);
      chk($sformatf("stall_rden[%0d]", i),  32'(wr_en),  32'd0);
    end
    ready = 1'b1;
    wait_done(400);
    @(posedge clk); #1;
    chk("run2_beats", 32'(beat_cnt), 32'd64);
    for (int i = 0; i < 64; i++) chk($sformatf("run2_addr[%0d]", i), 32'(beat_addr[i]), 32'(i));
    chk("run2_w10", 32'(beat_data[10]), 32'h10);
    chk("run2_w11", 32'(beat_data[11]), 32'h12);
    chk("run2_done_cnt", 32'(done_cnt), 32'd1);

    // Run 3: reset during column 3, then a fresh run from address 0.
    pulse_start();
    k = 0;
    while (!(wvalid && waddr >= 6'd24) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("col3_reached", 32'(waddr >> 3), 32'd3);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_edge_valid", 32'(wvalid), 32'd0);
    chk("midrst_edge_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    pulse_start();
    wait_done(400);
    @(posedge clk); #1;
    chk("run3_beats", 32'(beat_cnt), 32'd64);
    chk("run3_addr0", 32'(beat_addr[0]), 32'd0);
    chk("run3_w0", 32'(beat_data[0]), 32'h6A);
    chk("run3_addr63", 32'(beat_addr[63]), 32'd63);
    chk("run3_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wpu_weight_decoder.md
Name: wpu_weight_decoder

Overview:
- Read-side counterpart of the weight pre-processing unit. That unit stores 5-bit reduced weights in weight memory and up to 3 compensation entries per column in compensation memory.
- This block walks both memories column by column and reconstructs approximate 8-bit weights.
- Reconstructed weights stream to the systolic-array loader over a valid/ready interface. Memories are synchronous-read with 1-cycle latency.

Parameters:
- SIZE, 8, systolic array dimension (rows per column, number of columns).
- MEM_SIZE, SIZE*SIZE, weight memory depth.
- ADDR_WIDTH, $clog2(MEM_SIZE), weight memory address width.
- CROW_WIDTH, $clog2(SIZE), row index width.
- CMEM_SIZE, SIZE*3, compensation memory depth (3 slots per column).
- CMEM_ADDR_WIDTH, $clog2(CMEM_SIZE), compensation memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse: begin decoding the full matrix; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last weight is accepted.
- Weight_Mem_Rd_En  out  1  weight memory read enable.
- Weight_Mem_Rd_Addr  out  ADDR_WIDTH  weight address = col*SIZE + row.
- Reduced_Weight_in  in  5  weight memory read data, valid 1 cycle after Rd_En.
- Comp_Mem_Rd_En  out  1  compensation memory read enable.
- Comp_Mem_Rd_Addr  out  CMEM_ADDR_WIDTH  compensation address = col*3 + slot.
- Comp_Entry_in  in  CROW_WIDTH+4  {valid, row, cw[2:0]}, valid 1 cycle after Rd_En.
- Weight_out  out  8  reconstructed weight.
- Weight_Addr_out  out  ADDR_WIDTH  address of Weight_out.
- Weight_out_valid  out  1  Weight_out/Weight_Addr_out valid.
- Weight_out_ready  in  1  consumer accepts when valid&&ready.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, column/row/slot counters 0, compensation slot registers cleared (valid=0).
- FSM states:
  - IDLE: on start go to LOAD_COMP with col=0.
  - LOAD_COMP: issue Comp_Mem_Rd_En for slots 0,1,2 on 3 consecutive cycles. Capture each entry 1 cycle after its read, into slot registers 0..2. Go to STREAM after the third capture, i.e. 4 cycles in LOAD_COMP.
  - STREAM: issue weight reads for rows 0..SIZE-1 of the current column in order. Each returned word is reconstructed and loaded into the output register.
    - Last row of a non-final column accepted: col+1, go to LOAD_COMP.
    - Last row of final column (SIZE-1) accepted: go to DONE.
  - DONE: pulse done for 1 cycle, busy=0, return to IDLE.
- Backpressure:
  - Output register is 1 deep.
  - A weight read is issued only when no read is in flight and the output register is empty or being accepted that cycle.
  - While valid&&!ready, Weight_out, Weight_Addr_out and Weight_out_valid hold stable and no new read is issued.
  - With ready held high, throughput is 1 weight per 2 cycles (read, then output).
- Reconstruction, with R = Reduced_Weight_in and row r:
  - Compensation match: the lowest-index slot with valid=1 and row==r.
  - R[4]=1 and match: Weight_out = {R[3:0], cw, 1'b0}.
  - R[4]=1, no match: Weight_out = {R[3:0], 4'b0000}.
  - R[4]=0: Weight_out = {R[3],R[3],R[3],R[3:0],1'b0}. Any matching compensation slot is ignored.
  - Weight_Addr_out = col*SIZE + r.
- Boundaries:
  - A column with 0 valid slots decodes all rows without compensation.
  - Duplicate row entries: the lowest slot wins.
  - Counters wrap to 0 after the final column; the address never exceeds MEM_SIZE-1.
  - start asserted while busy: no effect.
  - start coincident with the done cycle: ignored; start is accepted only in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. An in-flight memory read is discarded.

Test Plan:
- Row 0 col 0 R=5'b10110, slot0={1,0,3'b101} -> Weight_out=8'b0110_1010, Weight_Addr_out=0.
- R=5'b01101 for row 2, no valid slots -> Weight_out=8'b1111_1010. R=5'b00011 -> 8'b0000_0110.
- Column 1 with slots {1,3,cw}, {1,5,cw}, {1,7,cw} and all R[4]=1 -> rows 3,5,7 carry cw in bits [3:1]; other rows have low nibble 0. Addresses 8..15 in order.
- Full 8x8 run with ready=1 -> exactly 64 valid beats, addresses 0..63 in order, a single done pulse, busy low afterwards.
- ready low for 5 cycles mid-stream -> output held stable, no read issued, no beat lost or duplicated.
- rst asserted during column 3 STREAM -> all outputs 0 next edge. A new start then decodes from address 0.
